// File: rtl/buf_requester_if.sv
// Wishbone initiator-side bus bundle between buf_requester and the buffer manager.
// master: the requester drives address/data/strobe/cycle/write; slave: the manager drives readdata/ack.
interface buf_requester_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] address;
    logic [DATA_WIDTH-1:0] writedata;
    logic [DATA_WIDTH-1:0] readdata;
    logic                  strobe;
    logic                  cycle;
    logic                  write;
    logic                  ack;

    modport master (
        output address, writedata, strobe, cycle, write,
        input  readdata, ack
    );

    modport slave (
        input  address, writedata, strobe, cycle, write,
        output readdata, ack
    );
endinterface

// File: rtl/buf_requester.sv
// buf_requester: Wishbone initiator that turns a local client's alloc/free requests into
// reads/writes of the buffer manager's single alloc/free register, and tracks held ids.
// Optional feature macro: BUF_REQ_TIMEOUT_EN (ack timeout of TIMEOUT_CYCLES, reported via err).
module buf_requester #(
    parameter int ADDR_WIDTH     = 16,
    parameter int DATA_WIDTH     = 32,
    parameter int BUF_REG_ADDR   = 0,
    parameter int CNT_WIDTH      = 8,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  alloc_req,
    input  logic                  free_req,
    input  logic [DATA_WIDTH-1:0] free_id,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] alloc_id,
    output logic                  alloc_empty,
    output logic                  err,
    output logic [CNT_WIDTH-1:0]  held_count,
    buf_requester_if.master       wbm
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ALLOC = 2'd1,
        FREE  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam logic [DATA_WIDTH-1:0] EMPTY_CODE = '1;
    localparam logic [CNT_WIDTH-1:0]  CNT_MAX    = '1;
    localparam logic [ADDR_WIDTH-1:0] REG_ADDR   = ADDR_WIDTH'(BUF_REG_ADDR);

`ifdef BUF_REQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
    logic [TW-1:0] timer_reg;
`else
    // Without the timeout feature the limit has no effect.
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
`endif

    state_t state_reg;

    // Request FSM with registered bus and client-side outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg     <= IDLE;
            done          <= 1'b0;
            alloc_id      <= '0;
            alloc_empty   <= 1'b0;
            err           <= 1'b0;
            held_count    <= '0;
            wbm.address   <= '0;
            wbm.writedata <= '0;
            wbm.strobe    <= 1'b0;
            wbm.cycle     <= 1'b0;
            wbm.write     <= 1'b0;
`ifdef BUF_REQ_TIMEOUT_EN
            timer_reg     <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state_reg)
                IDLE: begin
                    // Free wins a tie; a concurrent alloc stays pending on the client side.
                    if (free_req) begin
                        state_reg     <= FREE;
                        wbm.cycle     <= 1'b1;
                        wbm.strobe    <= 1'b1;
                        wbm.write     <= 1'b1;
                        wbm.address   <= REG_ADDR;
                        wbm.writedata <= free_id;
`ifdef BUF_REQ_TIMEOUT_EN
                        timer_reg     <= '0;
`endif
                    end else if (alloc_req) begin
                        state_reg     <= ALLOC;
                        wbm.cycle     <= 1'b1;
                        wbm.strobe    <= 1'b1;
                        wbm.write     <= 1'b0;
                        wbm.address   <= REG_ADDR;
                        wbm.writedata <= '0;
`ifdef BUF_REQ_TIMEOUT_EN
                        timer_reg     <= '0;
`endif
                    end
                end

                ALLOC, FREE: begin
                    // Bus outputs hold until ack; an ack on the expiry edge still counts as an ack.
                    if (wbm.ack) begin
                        state_reg     <= RESP;
                        done          <= 1'b1;
                        err           <= 1'b0;
                        wbm.cycle     <= 1'b0;
                        wbm.strobe    <= 1'b0;
                        wbm.write     <= 1'b0;
                        wbm.writedata <= '0;
                        if (state_reg == ALLOC) begin
                            alloc_id    <= wbm.readdata;
                            alloc_empty <= (wbm.readdata == EMPTY_CODE);
                            if (wbm.readdata != EMPTY_CODE && held_count != CNT_MAX)
                                held_count <= held_count + CNT_WIDTH'(1);
                        end else begin
                            if (held_count != '0)
                                held_count <= held_count - CNT_WIDTH'(1);
                        end
                    end
`ifdef BUF_REQ_TIMEOUT_EN
                    else if (timer_reg == TIMER_LAST) begin
                        state_reg     <= RESP;
                        done          <= 1'b1;
                        err           <= 1'b1;
                        wbm.cycle     <= 1'b0;
                        wbm.strobe    <= 1'b0;
                        wbm.write     <= 1'b0;
                        wbm.writedata <= '0;
                    end else begin
                        timer_reg <= timer_reg + TW'(1);
                    end
`endif
                end

                RESP: begin
                    // One-cycle done; IDLE samples requests only on the following edge.
                    state_reg <= IDLE;
                end

                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_buf_requester.sv
// Self-checking bench for buf_requester: a behavioural buffer-manager slave (FIFO id pool),
// a held-count scoreboard, directed scenarios plus a randomized alloc/free phase.
module tb_buf_requester;
    localparam int AW    = 16;
    localparam int DW    = 32;
    localparam int CW    = 8;
    localparam int NBUFS = 13;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          alloc_req = 1'b0;
    logic          free_req = 1'b0;
    logic [DW-1:0] free_id = '0;
    logic          done;
    logic [DW-1:0] alloc_id;
    logic          alloc_empty;
    logic          err;
    logic [CW-1:0] held_count;

    always #5 clk = ~clk;

    buf_requester_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    buf_requester #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BUF_REG_ADDR(0),
        .CNT_WIDTH(CW), .TIMEOUT_CYCLES(64)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .alloc_req   (alloc_req),
        .free_req    (free_req),
        .free_id     (free_id),
        .done        (done),
        .alloc_id    (alloc_id),
        .alloc_empty (alloc_empty),
        .err         (err),
        .held_count  (held_count),
        .wbm         (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- behavioural buffer manager ----------------
    bit            slave_en  = 1'b1;
    bit            rand_lat  = 1'b0;
    int            lat_target = 1;
    logic [DW-1:0] pool[$];
    int            slave_txns = 0;
    logic          slave_we;
    logic [AW-1:0] slave_addr;
    logic [DW-1:0] slave_wdata;
    logic [DW-1:0] slave_rdata;

    initial begin
        int lat;
        lat = 0;
        bus.ack = 1'b0;
        bus.readdata = '0;
        for (int i = 0; i < NBUFS; i++) pool.push_back(DW'(i));
        forever begin
            @(negedge clk);
            if (bus.ack) begin
                bus.ack = 1'b0;
                lat = 0;
            end else if (slave_en && bus.cycle && bus.strobe) begin
                lat++;
                if (lat >= lat_target) begin
                    slave_we    = bus.write;
                    slave_addr  = bus.address;
                    slave_wdata = bus.writedata;
                    slave_txns++;
                    if (bus.write) begin
                        pool.push_back(bus.writedata);
                        slave_rdata = '0;
                    end else if (pool.size() > 0) begin
                        slave_rdata = pool.pop_front();
                    end else begin
                        slave_rdata = '1;
                    end
                    bus.readdata = slave_rdata;
                    bus.ack = 1'b1;
                    lat_target = rand_lat ? int'($urandom_range(1, 4)) : 1;
                end
            end else begin
                lat = 0;
            end
        end
    end

    // ---------------- scoreboard / model ----------------
    int            exp_cnt = 0;
    int            exp_txns = 0;
    logic [DW-1:0] exp_alloc_id = '0;
    logic [DW-1:0] held_q[$];

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("done_timeout", 0, 1);
    endtask

    // Checks after an alloc completion (called at the negedge where done is high).
    task automatic check_alloc_result();
        bit empty;
        exp_txns++;
        empty = (slave_rdata == '1);
        if (!empty) begin
            held_q.push_back(slave_rdata);
            exp_cnt = (exp_cnt < 255) ? exp_cnt + 1 : 255;
        end
        exp_alloc_id = empty ? '1 : slave_rdata;
        $display("alloc: id=%0h empty=%0b held=%0d", alloc_id, alloc_empty, held_count);
        check("alloc_we", slave_we, 0);
        check("alloc_addr", slave_addr, 0);
        check("alloc_id", alloc_id, exp_alloc_id);
        check("alloc_empty", alloc_empty, empty);
        check("alloc_err", err, 0);
        check("alloc_held", held_count, exp_cnt);
        check("alloc_txns", slave_txns, exp_txns);
    endtask

    task automatic check_free_result(input logic [DW-1:0] id);
        exp_txns++;
        exp_cnt = (exp_cnt > 0) ? exp_cnt - 1 : 0;
        $display("free: id=%0h held=%0d", id, held_count);
        check("free_we", slave_we, 1);
        check("free_addr", slave_addr, 0);
        check("free_wdata", slave_wdata, id);
        check("free_err", err, 0);
        check("free_held", held_count, exp_cnt);
        check("free_txns", slave_txns, exp_txns);
    endtask

    task automatic do_alloc();
        bit ok;
        alloc_req = 1'b1;
        wait_done(ok);
        alloc_req = 1'b0;
        if (ok) begin
            check_alloc_result();
            @(negedge clk);
            check("done_pulse", done, 0);
        end
    endtask

    task automatic do_free(input logic [DW-1:0] id);
        bit ok;
        free_id = id;
        free_req = 1'b1;
        wait_done(ok);
        free_req = 1'b0;
        if (ok) begin
            check_free_result(id);
            @(negedge clk);
            check("done_pulse", done, 0);
        end
    endtask

    task automatic drop_held(input logic [DW-1:0] id);
        for (int k = 0; k < held_q.size(); k++) begin
            if (held_q[k] == id) begin
                held_q.delete(k);
                break;
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int cnt;

        // Reset held low for 10 cycles: everything idle and zero.
        repeat (10) @(negedge clk);
        check("rst_done", done, 0);
        check("rst_alloc_id", alloc_id, 0);
        check("rst_empty", alloc_empty, 0);
        check("rst_err", err, 0);
        check("rst_held", held_count, 0);
        check("rst_cyc", bus.cycle, 0);
        check("rst_stb", bus.strobe, 0);
        check("rst_we", bus.write, 0);
        check("rst_addr", bus.address, 0);
        check("rst_wdata", bus.writedata, 0);
        reset = 1'b1;
        cnt = 0;
        repeat (5) begin
            @(negedge clk);
            if (bus.cycle || bus.strobe || done) cnt++;
        end
        check("idle_bus", cnt, 0);

        // Allocate every buffer (ids 0..12, ack one cycle after strobe).
        for (int i = 0; i < NBUFS; i++) begin
            do_alloc();
            check("alloc_seq_id", alloc_id, i);
        end
        check("held_full", held_count, NBUFS);

        // 14th alloc hits the empty code.
        do_alloc();
        check("empty_flag", alloc_empty, 1);
        check("empty_held", held_count, NBUFS);

        // Free id 5.
        drop_held(DW'(5));
        do_free(DW'(5));
        check("free5_held", held_count, NBUFS - 1);

        // Simultaneous alloc and free: free goes first, alloc follows.
        free_id = DW'(7);
        alloc_req = 1'b1;
        free_req = 1'b1;
        wait_done(ok);
        free_req = 1'b0;
        if (ok) begin
            drop_held(DW'(7));
            check_free_result(DW'(7));
            wait_done(ok);
            if (ok) begin
                check_alloc_result();
                check("tie_alloc_id", alloc_id, 5);
            end
        end
        alloc_req = 1'b0;
        @(negedge clk);

        // Randomized alloc/free mix with random ack latency.
        rand_lat = 1'b1;
        lat_target = 2;
        for (int t = 0; t < 40; t++) begin
            if ($urandom_range(0, 1) == 0) begin
                do_alloc();
            end else begin
                logic [DW-1:0] id;
                if (held_q.size() > 0) begin
                    int k;
                    k = int'($urandom_range(0, held_q.size() - 1));
                    id = held_q[k];
                    held_q.delete(k);
                end else begin
                    id = DW'($urandom_range(100, 200));
                end
                do_free(id);
            end
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        // Drain the held set, then one extra free at zero to check saturation.
        while (held_q.size() > 0) do_free(held_q.pop_front());
        do_free(DW'(3));
        check("sat_zero_held", held_count, 0);

`ifdef BUF_REQ_TIMEOUT_EN
        // No ack ever: strobe held for exactly 64 cycles, then done with err.
        slave_en = 1'b0;
        alloc_req = 1'b1;
        cnt = 0;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (done) begin
                ok = 1'b1;
                break;
            end
            if (bus.strobe) cnt++;
        end
        alloc_req = 1'b0;
        $display("timeout: strobe_cycles=%0d err=%0b", cnt, err);
        check("to_done_seen", ok, 1);
        check("to_strobe_cycles", cnt, 64);
        check("to_err", err, 1);
        check("to_held", held_count, exp_cnt);
        check("to_alloc_id", alloc_id, exp_alloc_id);
        check("to_cyc", bus.cycle, 0);
        @(negedge clk);
        slave_en = 1'b1;
`endif

        // Reset in the middle of an alloc: bus drops at once, no done.
        slave_en = 1'b0;
        alloc_req = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.strobe) begin
                ok = 1'b1;
                break;
            end
        end
        check("mid_strobe_up", ok, 1);
        #2 reset = 1'b0;
        #1;
        $display("reset mid-alloc: cyc=%0b stb=%0b", bus.cycle, bus.strobe);
        check("mid_rst_cyc", bus.cycle, 0);
        check("mid_rst_stb", bus.strobe, 0);
        check("mid_rst_held", held_count, 0);
        alloc_req = 1'b0;
        cnt = 0;
        repeat (3) begin
            @(negedge clk);
            if (done) cnt++;
        end
        reset = 1'b1;
        exp_cnt = 0;
        repeat (5) begin
            @(negedge clk);
            if (done || bus.cycle) cnt++;
        end
        check("mid_rst_no_done", cnt, 0);
        slave_en = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
